// File: rtl/aes_2om_pkg.sv
// Shared types and defaults for the 3-share masked AES round sequencer.
// The per-round randomness refresh is selected with AES_2OM_RND_PER_ROUND_EN.
package aes_2om_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RWAIT = 3'd2,
    ST_SBOX  = 3'd3,
    ST_LIN   = 3'd4,
    ST_FIN   = 3'd5
  } aes_2om_state_e;

  localparam int SBOX_LAT_DEF = 4;
  localparam int ROUNDS_DEF   = 10;
  localparam int RW_DEF       = 4;

  // A one-cycle Sbox still needs a 1-bit counter.
  function automatic int lat_cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  localparam int LAT_W_DEF = lat_cnt_w(SBOX_LAT_DEF);

endpackage

// File: rtl/aes_2om_lat_cnt.sv
// Loadable down-counter timing the masked Sbox pipeline; tc_o flags the last cycle.
module aes_2om_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/aes_2om_round_ctrl.sv
// Round sequencer for the 3-share masked AES core (load, Sbox layer, linear layer).
// Define AES_2OM_RND_PER_ROUND_EN to wait for fresh randomness before every Sbox pass.
module aes_2om_round_ctrl
  import aes_2om_pkg::*;
#(
  parameter int SBOX_LAT = SBOX_LAT_DEF,
  parameter int ROUNDS   = ROUNDS_DEF,
  parameter int RW       = RW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic           rnd_valid_i,
  output logic           rnd_req_o,
  output logic           guards_mux_sel_o,
  output logic           state_load_o,
  output logic           state_en_o,
  output logic           last_round_o,
  output logic           key_en_o,
  output logic [RW-1:0]  round_o,
  output logic           busy_o,
  output logic           done_o,
  output aes_2om_state_e dbg_state_o
);

  localparam int LW = lat_cnt_w(SBOX_LAT);

  // PRNG handshake: rnd_valid_i says the randomness words are fresh; rnd_req_o is
  // asserted in the same cycle the words are consumed, and only when rnd_valid_i is high.

  aes_2om_state_e state_q, state_d;
  logic [RW-1:0]  round_q, round_d;
  logic           rnd_req;
  logic           lat_tc;
  logic           lat_load;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rnd_req = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      round_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_LOAD;
            round_d = RW'(1);
          end
        end
        ST_LOAD:  state_d = ST_RWAIT;
        ST_RWAIT: begin
          if (rnd_valid_i) begin
            rnd_req = 1'b1;
            state_d = ST_SBOX;
          end
        end
        ST_SBOX: begin
          if (lat_tc) state_d = ST_LIN;
        end
        ST_LIN: begin
          if (round_q >= RW'(ROUNDS)) begin
            state_d = ST_FIN;
          end else begin
            round_d = round_q + RW'(1);
`ifdef AES_2OM_RND_PER_ROUND_EN
            state_d = ST_RWAIT;
`else
            state_d = ST_SBOX;
`endif
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          round_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          round_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Counter is reloaded on every entry into SBOX, so it never carries over between rounds.
  assign lat_load = (state_d == ST_SBOX) && (state_q != ST_SBOX);

  aes_2om_lat_cnt #(.W(LW)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort_i),
    .load_i     (lat_load),
    .load_val_i (LW'(SBOX_LAT - 1)),
    .en_i       (state_q == ST_SBOX),
    .tc_o       (lat_tc)
  );

  assign rnd_req_o        = rnd_req;
  assign guards_mux_sel_o = (state_q == ST_SBOX) && (round_q == RW'(1));
  assign state_load_o     = (state_q == ST_LOAD);
  assign state_en_o       = (state_q == ST_LOAD) || (state_q == ST_LIN);
  assign key_en_o         = (state_q == ST_LIN);
  assign last_round_o     = (state_q != ST_IDLE) && (round_q == RW'(ROUNDS));
  assign round_o          = round_q;
  assign busy_o           = (state_q == ST_LOAD) || (state_q == ST_RWAIT) ||
                            (state_q == ST_SBOX) || (state_q == ST_LIN);
  assign done_o           = (state_q == ST_FIN);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_aes_2om_round_ctrl.sv
// Scoreboard bench for aes_2om_round_ctrl: directed runs, per-block expectations checked on done_o.
module tb_aes_2om_round_ctrl;
  import aes_2om_pkg::*;

  localparam int ROUNDS = 10;

`ifdef AES_2OM_RND_PER_ROUND_EN
  localparam int LAT_EXP     = 62;
  localparam int REQ_EXP     = 10;
  localparam int LAST_EXP    = 7;
  localparam int WAIT_REL    = 20;  // RWAIT of round 4
  localparam int FG_STALL    = 3;
  localparam int ABORT_REL   = 40;  // inside SBOX of round 7
  localparam int LIN3_REL    = 19;
`else
  localparam int LAT_EXP     = 53;
  localparam int REQ_EXP     = 1;
  localparam int LAST_EXP    = 6;
  localparam int WAIT_REL    = 2;   // the single RWAIT before round 1
  localparam int FG_STALL    = 8;
  localparam int ABORT_REL   = 34;
  localparam int LIN3_REL    = 17;
`endif

  typedef struct {
    int lat;
    int req;
    int key;
    int last;
    int guard;
    int first_g;
  } exp_t;

  logic           clk, rst_n, start_i, abort_i, rnd_valid_i;
  logic           rnd_req_o, guards_mux_sel_o, state_load_o, state_en_o;
  logic           last_round_o, key_en_o, busy_o, done_o;
  logic [3:0]     round_o;
  aes_2om_state_e dbg_state;

  aes_2om_round_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .rnd_valid_i      (rnd_valid_i),
    .rnd_req_o        (rnd_req_o),
    .guards_mux_sel_o (guards_mux_sel_o),
    .state_load_o     (state_load_o),
    .state_en_o       (state_en_o),
    .last_round_o     (last_round_o),
    .key_en_o         (key_en_o),
    .round_o          (round_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   start_cyc = 0;
  int   m_req, m_key, m_last, m_guard, m_fg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    m_req = 0; m_key = 0; m_last = 0; m_guard = 0; m_fg = -1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rnd_req_o)    m_req++;
      if (key_en_o)     m_key++;
      if (last_round_o) m_last++;
      if (guards_mux_sel_o) begin
        m_guard++;
        if (m_fg < 0) m_fg = cyc - start_cyc;
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no done", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency",       cyc - start_cyc, e.lat);
          check("rnd_req_count", m_req,   e.req);
          check("key_en_count",  m_key,   e.key);
          check("last_rnd_cnt",  m_last,  e.last);
          check("guard_count",   m_guard, e.guard);
          check("first_guard",   m_fg,    e.first_g);
          check("round_at_done", round_o, ROUNDS);
          check("busy_at_done",  busy_o,  0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_start();
    start_i   = 1'b1;
    start_cyc = cyc;
    clear_counts();
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic to_rel(input int r);
    for (int i = 0; i < 1000 && cyc < start_cyc + r; i++) tick(1);
  endtask

  task automatic push_exp(input int lat, input int first_g);
    exp_t e;
    e.lat = lat; e.req = REQ_EXP; e.key = ROUNDS;
    e.last = LAST_EXP; e.guard = 4; e.first_g = first_g;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: got %0d pending blocks expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(3);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {rnd_req_o, guards_mux_sel_o, state_load_o, state_en_o, last_round_o,
                 key_en_o, busy_o, done_o, round_o}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; rnd_valid_i = 1'b0;
    clear_counts();
    tick(3);
    check_all_zero("reset_outputs");
    check("reset_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick(2);

    // 1: nominal block, randomness always available
    rnd_valid_i = 1'b1;
    push_exp(LAT_EXP, 3);
    do_start();
    to_rel(1);
    check("load_pulse", {state_load_o, state_en_o, busy_o}, 3'b111);
    to_rel(3);
    check("guard_r1_sbox", guards_mux_sel_o, 1);
    wait_drain();
    check("round_idle", round_o, 0);

    // 2: randomness missing for 5 cycles in an RWAIT
    push_exp(LAT_EXP + 5, FG_STALL);
    do_start();
    to_rel(WAIT_REL);
    rnd_valid_i = 1'b0;
    tick(2);
    check("rwait_hold", {dbg_state, rnd_req_o}, {ST_RWAIT, 1'b0});
    to_rel(WAIT_REL + 5);
    rnd_valid_i = 1'b1;
    #1;
    check("rnd_req_on_valid", rnd_req_o, 1);
    wait_drain();

    // 3: abort inside SBOX of round 7, then a clean block
    do_start();
    to_rel(ABORT_REL);
    check("sbox_before_abort", dbg_state, ST_SBOX);
    check("round7", round_o, 7);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    check("abort_idle", dbg_state, ST_IDLE);
    check_all_zero("abort_outputs");
    tick(70);
    push_exp(LAT_EXP, 3);
    do_start();
    wait_drain();

    // 4: start pulses while busy are ignored
    push_exp(LAT_EXP, 3);
    do_start();
    to_rel(10);
    pulse_start();
    to_rel(30);
    pulse_start();
    to_rel(LAT_EXP - 1);
    check("last_round_pre_fin", last_round_o, 1);
    wait_drain();
    tick(20);

    // 5: reset during LIN of round 3
    do_start();
    to_rel(LIN3_REL);
    check("lin_round3", {key_en_o, state_en_o, round_o}, {1'b1, 1'b1, 4'd3});
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post_reset_round", round_o, 0);
    check("post_reset_state", dbg_state, ST_IDLE);
    push_exp(LAT_EXP, 3);
    do_start();
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
